// File: rtl/cmos_tx_pkg.sv
// Shared definitions for the CMOS video transmitter: register map, FSM states,
// test pattern codes and small helpers.
package cmos_tx_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_HACTIVE = 3'd1;
    localparam logic [2:0] REG_VACTIVE = 3'd2;
    localparam logic [2:0] REG_HBLANK  = 3'd3;
    localparam logic [2:0] REG_VBLANK  = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VBLANK,
        ST_HBLANK,
        ST_ACTIVE
    } state_t;

    typedef enum logic [1:0] {
        PAT_X,
        PAT_Y,
        PAT_FRAME,
        PAT_CHECKER
    } pat_t;

    function automatic logic [15:0] clamp1(input logic [15:0] v);
        return (v == '0) ? 16'd1 : v;
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [31:0] d,
                                            input logic [3:0] sel);
        return {sel[1] ? d[15:8] : old[15:8], sel[0] ? d[7:0] : old[7:0]};
    endfunction

endpackage

// File: rtl/cmos_tx_timing.sv
// Pixel prescaler, line/frame counters, timing FSM and registered video outputs.
module cmos_tx_timing
    import cmos_tx_pkg::*;
#(
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned HSYNC_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pat,
    input  logic [15:0] hactive,
    input  logic [15:0] vactive,
    input  logic [15:0] hblank,
    input  logic [15:0] vblank,
    output logic        cmos_clk,
    output logic [15:0] data,
    output logic        vsync,
    output logic        hsync,
    output logic        valid,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int unsigned PW = $clog2(PIX_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PIX_DIV - 1);
    localparam logic [PW-1:0] CLK_HIGH   = PW'(PIX_DIV / 2);
    localparam logic [16:0]   HSYNC_LIM  = 17'(HSYNC_W);

    logic [PW-1:0] presc;
    logic          strobe;
    state_t        state, state_nx;
    logic [16:0]   hcnt, hcnt_nx, vcnt, vcnt_nx;
    logic [15:0]   sh_ha, sh_va, sh_hb, sh_vb;
    logic [15:0]   sh_ha_nx, sh_va_nx, sh_hb_nx, sh_vb_nx;
    pat_t          sh_pat, pat_nx;
    logic [15:0]   cnt_nx;
    logic          latch, run, line_end, frame_end;
    logic [15:0]   x, y, pix;
    logic [16:0]   hs_lim;

    assign strobe   = (presc == PRESC_LAST);
    assign cmos_clk = (presc < CLK_HIGH);
    assign busy     = (state != ST_IDLE);

    // Next pixel position is computed first; state and outputs derive from it,
    // using the freshly latched shadows when a new frame begins.
    always_comb begin
        state_nx  = state;
        hcnt_nx   = hcnt;
        vcnt_nx   = vcnt;
        sh_ha_nx  = sh_ha;
        sh_va_nx  = sh_va;
        sh_hb_nx  = sh_hb;
        sh_vb_nx  = sh_vb;
        pat_nx    = sh_pat;
        cnt_nx    = frame_cnt;
        latch     = 1'b0;
        run       = 1'b0;
        line_end  = (hcnt == ({1'b0, sh_hb} + {1'b0, sh_ha} - 17'd1));
        frame_end = line_end && (vcnt == ({1'b0, sh_vb} + {1'b0, sh_va} - 17'd1));
        if (strobe) begin
            if (state == ST_IDLE) begin
                latch   = en;
                run     = en;
                hcnt_nx = '0;
                vcnt_nx = '0;
            end else if (!line_end) begin
                hcnt_nx = hcnt + 17'd1;
                run     = 1'b1;
            end else if (!frame_end) begin
                hcnt_nx = '0;
                vcnt_nx = vcnt + 17'd1;
                run     = 1'b1;
            end else begin
                hcnt_nx = '0;
                vcnt_nx = '0;
                cnt_nx  = frame_cnt + 16'd1;
                latch   = en;
                run     = en;
            end
        end
        if (latch) begin
            sh_ha_nx = clamp1(hactive);
            sh_va_nx = clamp1(vactive);
            sh_hb_nx = clamp1(hblank);
            sh_vb_nx = clamp1(vblank);
            pat_nx   = pat_t'(pat);
        end
        if (strobe) begin
            if (!run)
                state_nx = ST_IDLE;
            else if (vcnt_nx < {1'b0, sh_vb_nx})
                state_nx = ST_VBLANK;
            else if (hcnt_nx < {1'b0, sh_hb_nx})
                state_nx = ST_HBLANK;
            else
                state_nx = ST_ACTIVE;
        end
    end

    always_comb begin
        x      = hcnt_nx[15:0] - sh_hb_nx;
        y      = vcnt_nx[15:0] - sh_vb_nx;
        hs_lim = (HSYNC_LIM < {1'b0, sh_hb_nx}) ? HSYNC_LIM : {1'b0, sh_hb_nx};
        case (pat_nx)
            PAT_X:     pix = x;
            PAT_Y:     pix = y;
            PAT_FRAME: pix = cnt_nx;
            default:   pix = (x[3] ^ y[3]) ? '1 : '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            state     <= ST_IDLE;
            hcnt      <= '0;
            vcnt      <= '0;
            sh_ha     <= '0;
            sh_va     <= '0;
            sh_hb     <= '0;
            sh_vb     <= '0;
            sh_pat    <= PAT_X;
            frame_cnt <= '0;
            data      <= '0;
            vsync     <= 1'b0;
            hsync     <= 1'b0;
            valid     <= 1'b0;
        end else begin
            presc     <= strobe ? '0 : presc + 1'b1;
            state     <= state_nx;
            hcnt      <= hcnt_nx;
            vcnt      <= vcnt_nx;
            sh_ha     <= sh_ha_nx;
            sh_va     <= sh_va_nx;
            sh_hb     <= sh_hb_nx;
            sh_vb     <= sh_vb_nx;
            sh_pat    <= pat_nx;
            frame_cnt <= cnt_nx;
            if (strobe) begin
                vsync <= run && (vcnt_nx == '0);
                hsync <= run && (hcnt_nx < hs_lim);
                valid <= (state_nx == ST_ACTIVE);
                data  <= (state_nx == ST_ACTIVE) ? pix : '0;
            end
        end
    end

endmodule

// File: rtl/cmos_tx.sv
// Wishbone register block for the CMOS video transmitter; wraps the timing core.
module cmos_tx
    import cmos_tx_pkg::*;
#(
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned HSYNC_W = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        cmos_clk_o,
    output logic [15:0] cmos_data_o,
    output logic        cmos_vsync_o,
    output logic        cmos_hsync_o,
    output logic        cmos_valid_o
);

    logic [2:0]  ctrl, ctrl_nx;
    logic [15:0] hactive, hactive_nx, vactive, vactive_nx;
    logic [15:0] hblank, hblank_nx, vblank, vblank_nx;
    logic [15:0] frame_cnt;
    logic        busy, req, wr;
    logic [2:0]  idx;
    logic [31:0] rdata;
    logic        unused;

    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr     = req & wb_we_i;
    assign idx    = wb_adr_i[4:2];
    assign unused = &{1'b0, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    // Post-write values feed the timing core so a write landing on the frame-end
    // edge is captured in the new shadows.
    always_comb begin
        ctrl_nx    = ctrl;
        hactive_nx = hactive;
        vactive_nx = vactive;
        hblank_nx  = hblank;
        vblank_nx  = vblank;
        if (wr) begin
            case (idx)
                REG_CTRL:    if (wb_sel_i[0]) ctrl_nx = wb_dat_i[2:0];
                REG_HACTIVE: hactive_nx = merge16(hactive, wb_dat_i, wb_sel_i);
                REG_VACTIVE: vactive_nx = merge16(vactive, wb_dat_i, wb_sel_i);
                REG_HBLANK:  hblank_nx  = merge16(hblank, wb_dat_i, wb_sel_i);
                REG_VBLANK:  vblank_nx  = merge16(vblank, wb_dat_i, wb_sel_i);
                default:     ;
            endcase
        end
    end

    always_comb begin
        case (idx)
            REG_CTRL:    rdata = {29'b0, ctrl};
            REG_HACTIVE: rdata = {16'b0, hactive};
            REG_VACTIVE: rdata = {16'b0, vactive};
            REG_HBLANK:  rdata = {16'b0, hblank};
            REG_VBLANK:  rdata = {16'b0, vblank};
            REG_STATUS:  rdata = {15'b0, busy, frame_cnt};
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ctrl     <= '0;
            hactive  <= '0;
            vactive  <= '0;
            hblank   <= '0;
            vblank   <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            ctrl     <= ctrl_nx;
            hactive  <= hactive_nx;
            vactive  <= vactive_nx;
            hblank   <= hblank_nx;
            vblank   <= vblank_nx;
            wb_ack_o <= req;
            wb_dat_o <= req ? rdata : '0;
        end
    end

    cmos_tx_timing #(
        .PIX_DIV (PIX_DIV),
        .HSYNC_W (HSYNC_W)
    ) u_timing (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .en        (ctrl_nx[0]),
        .pat       (ctrl_nx[2:1]),
        .hactive   (hactive_nx),
        .vactive   (vactive_nx),
        .hblank    (hblank_nx),
        .vblank    (vblank_nx),
        .cmos_clk  (cmos_clk_o),
        .data      (cmos_data_o),
        .vsync     (cmos_vsync_o),
        .hsync     (cmos_hsync_o),
        .valid     (cmos_valid_o),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

endmodule
